// File: rtl/port_packet_fifo.sv
// Per-output-port packet FIFO: DEPTH x (DW+1) entries, each a byte plus its last-byte tag.
// Latency: written byte readable the cycle after the write; rdata/rlast registered one cycle after rinc.
// Backpressure: wfull rejects and counts dropped writes; walmost_full warns early; reads ignored when empty.
module port_packet_fifo #(
    parameter int DW        = 8,
    parameter int AW        = 4,
    parameter int AF_MARGIN = 2
) (
    input  logic          clk1,
    input  logic          rst,
    input  logic          winc,
    input  logic [DW-1:0] wdata,
    input  logic          wlast,
    output logic          wfull,
    output logic          walmost_full,
    input  logic          rinc,
    output logic [DW-1:0] rdata,
    output logic          rlast,
    output logic          rempty,
    output logic          pkt_avail,
    output logic [7:0]    drop_cnt
);

    localparam int         DEPTH  = 1 << AW;
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);
    localparam logic [AW:0] AF_LVL   = (AW+1)'(DEPTH - AF_MARGIN);

    // Storage: {last tag, byte}. Not reset; the pointers and count define validity.
    logic [DW:0]   mem_q [DEPTH];

    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [AW:0]   count_q, count_d;
    logic [AW:0]   pkt_cnt_q, pkt_cnt_d;
    logic [7:0]    drop_q, drop_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          rlast_q, rlast_d;

    logic          wr_acc;
    logic          rd_acc;
    logic          pkt_in;
    logic          pkt_out;
    logic [DW:0]   rd_entry;

    // Status flags come only from the registered occupancy count.
    assign wfull        = (count_q == FULL_LVL);
    assign rempty       = (count_q == '0);
    assign walmost_full = (count_q >= AF_LVL);
    assign pkt_avail    = (pkt_cnt_q != '0);
    assign drop_cnt     = drop_q;
    assign rdata        = rdata_q;
    assign rlast        = rlast_q;

    // When full, a simultaneous read does not free space for the write in the same
    // cycle; when empty, a simultaneous write is not bypassed to the read port.
    assign wr_acc   = winc && !wfull;
    assign rd_acc   = rinc && !rempty;
    assign rd_entry = mem_q[rptr_q];
    assign pkt_in   = wr_acc && wlast;
    assign pkt_out  = rd_acc && rd_entry[DW];

    // Next-state for pointers, counters and the registered read port.
    always_comb begin
        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        count_d   = count_q;
        pkt_cnt_d = pkt_cnt_q;
        drop_d    = drop_q;
        rdata_d   = rdata_q;
        rlast_d   = rlast_q;

        if (wr_acc) begin
            wptr_d = wptr_q + 1'b1;
        end

        if (rd_acc) begin
            rptr_d  = rptr_q + 1'b1;
            rdata_d = rd_entry[DW-1:0];
            rlast_d = rd_entry[DW];
        end

        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        case ({pkt_in, pkt_out})
            2'b10:   pkt_cnt_d = pkt_cnt_q + 1'b1;
            2'b01:   pkt_cnt_d = pkt_cnt_q - 1'b1;
            default: pkt_cnt_d = pkt_cnt_q;
        endcase

        if (winc && wfull && (drop_q != 8'hFF)) begin
            drop_d = drop_q + 1'b1;
        end
    end

    // State registers with synchronous active-low reset taking priority over traffic.
    always_ff @(posedge clk1) begin
        if (!rst) begin
            wptr_q    <= '0;
            rptr_q    <= '0;
            count_q   <= '0;
            pkt_cnt_q <= '0;
            drop_q    <= '0;
            rdata_q   <= '0;
            rlast_q   <= 1'b0;
        end else begin
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            count_q   <= count_d;
            pkt_cnt_q <= pkt_cnt_d;
            drop_q    <= drop_d;
            rdata_q   <= rdata_d;
            rlast_q   <= rlast_d;
        end
    end

    // Memory write; suppressed during reset so a reset cycle never stores a byte.
    always_ff @(posedge clk1) begin
        if (rst && wr_acc) begin
            mem_q[wptr_q] <= {wlast, wdata};
        end
    end

endmodule

// File: tb/tb_port_packet_fifo.sv
// Directed bench for port_packet_fifo: packet ordering, full/empty corner cases, wrap, reset, drop saturation.
// Inputs change 1 time unit after the rising edge; outputs are sampled at that same point.
// Every step has a fixed number of cycles, so the run always terminates.
module tb_port_packet_fifo;

    logic       clk1 = 1'b0;
    logic       rst;
    logic       winc;
    logic [7:0] wdata;
    logic       wlast;
    logic       wfull;
    logic       walmost_full;
    logic       rinc;
    logic [7:0] rdata;
    logic       rlast;
    logic       rempty;
    logic       pkt_avail;
    logic [7:0] drop_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    port_packet_fifo #(.DW(8), .AW(4), .AF_MARGIN(2)) dut (
        .clk1         (clk1),
        .rst          (rst),
        .winc         (winc),
        .wdata        (wdata),
        .wlast        (wlast),
        .wfull        (wfull),
        .walmost_full (walmost_full),
        .rinc         (rinc),
        .rdata        (rdata),
        .rlast        (rlast),
        .rempty       (rempty),
        .pkt_avail    (pkt_avail),
        .drop_cnt     (drop_cnt)
    );

    always #5 clk1 = ~clk1;

    task automatic tick();
        @(posedge clk1);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic write_byte(input logic [7:0] d, input logic last);
        winc  = 1'b1;
        wdata = d;
        wlast = last;
        tick();
        winc  = 1'b0;
        wlast = 1'b0;
    endtask

    task automatic read_byte(input string tag, input logic [7:0] exp_d, input logic exp_l);
        rinc = 1'b1;
        tick();
        rinc = 1'b0;
        chk({tag, "_rdata"}, 32'(rdata), 32'(exp_d));
        chk({tag, "_rlast"}, 32'(rlast), 32'(exp_l));
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_rempty"}, 32'(rempty), 32'd1);
        chk({tag, "_wfull"}, 32'(wfull), 32'd0);
        chk({tag, "_walmost"}, 32'(walmost_full), 32'd0);
        chk({tag, "_pkt_avail"}, 32'(pkt_avail), 32'd0);
        chk({tag, "_drop_cnt"}, 32'(drop_cnt), 32'd0);
        chk({tag, "_rdata"}, 32'(rdata), 32'd0);
        chk({tag, "_rlast"}, 32'(rlast), 32'd0);
    endtask

    initial begin
        logic [7:0] pkt [4];
        logic [7:0] prev;
        logic [7:0] cur;

        rst   = 1'b0;
        winc  = 1'b0;
        rinc  = 1'b0;
        wdata = 8'h00;
        wlast = 1'b0;
        tick();
        tick();
        check_reset_outputs("reset");
        rst = 1'b1;
        tick();

        // Four-byte packet, last tag on the CRC byte.
        pkt[0] = 8'h01; pkt[1] = 8'h05; pkt[2] = 8'h81; pkt[3] = 8'hAA;
        for (int i = 0; i < 4; i++) begin
            write_byte(pkt[i], i == 3);
            if (i == 2) chk("pkt_avail_partial", 32'(pkt_avail), 32'd0);
        end
        chk("pkt_avail_complete", 32'(pkt_avail), 32'd1);
        chk("rempty_after_pkt", 32'(rempty), 32'd0);
        for (int i = 0; i < 4; i++) begin
            read_byte("pkt4_read", pkt[i], i == 3);
        end
        chk("pkt4_rempty", 32'(rempty), 32'd1);
        chk("pkt4_pkt_avail", 32'(pkt_avail), 32'd0);

        // Fill all 16 entries; check thresholds on the way.
        for (int i = 0; i < 16; i++) begin
            winc  = 1'b1;
            wdata = 8'(8'h10 + i);
            wlast = (i == 15);
            tick();
            if (i == 12) chk("walmost_13", 32'(walmost_full), 32'd0);
            if (i == 13) chk("walmost_14", 32'(walmost_full), 32'd1);
            if (i == 14) chk("wfull_15", 32'(wfull), 32'd0);
            if (i == 15) chk("wfull_16", 32'(wfull), 32'd1);
        end
        wdata = 8'hEE;
        wlast = 1'b0;
        tick();
        winc = 1'b0;
        chk("drop_17th", 32'(drop_cnt), 32'd1);
        chk("wfull_17th", 32'(wfull), 32'd1);

        // Full with simultaneous write and read: read wins, write dropped.
        winc  = 1'b1;
        wdata = 8'h77;
        rinc  = 1'b1;
        tick();
        winc = 1'b0;
        rinc = 1'b0;
        chk("full_both_rdata", 32'(rdata), 32'h10);
        chk("full_both_drop", 32'(drop_cnt), 32'd2);
        chk("full_both_wfull", 32'(wfull), 32'd0);
        chk("full_both_walmost", 32'(walmost_full), 32'd1);
        for (int i = 1; i < 16; i++) begin
            read_byte("drain", 8'(8'h10 + i), i == 15);
        end
        chk("drain_rempty", 32'(rempty), 32'd1);
        chk("drain_pkt_avail", 32'(pkt_avail), 32'd0);

        // Read while empty is ignored: outputs hold.
        rinc = 1'b1;
        tick();
        rinc = 1'b0;
        chk("empty_read_rdata", 32'(rdata), 32'h1F);
        chk("empty_read_rlast", 32'(rlast), 32'd1);
        chk("empty_read_rempty", 32'(rempty), 32'd1);

        // Empty with simultaneous write and read: write accepted, read ignored.
        winc  = 1'b1;
        wdata = 8'h3C;
        rinc  = 1'b1;
        tick();
        winc = 1'b0;
        rinc = 1'b0;
        chk("empty_both_rdata", 32'(rdata), 32'h1F);
        chk("empty_both_rempty", 32'(rempty), 32'd0);
        read_byte("empty_both_next", 8'h3C, 1'b0);
        chk("empty_both_drained", 32'(rempty), 32'd1);

        // 40 bytes streamed at one-byte occupancy; pointers wrap twice.
        winc  = 1'b1;
        wdata = 8'd3;
        tick();
        for (int i = 1; i < 40; i++) begin
            prev  = 8'(i * 7 - 4);
            cur   = 8'(i * 7 + 3);
            winc  = 1'b1;
            wdata = cur;
            rinc  = 1'b1;
            tick();
            chk("stream_rdata", 32'(rdata), 32'(prev));
        end
        winc = 1'b0;
        read_byte("stream_last", 8'(39 * 7 + 3), 1'b0);
        chk("stream_rempty", 32'(rempty), 32'd1);
        chk("stream_drop", 32'(drop_cnt), 32'd2);

        // Partial packet, then reset with traffic asserted.
        write_byte(8'hA1, 1'b0);
        write_byte(8'hA2, 1'b0);
        write_byte(8'hA3, 1'b0);
        rst   = 1'b0;
        winc  = 1'b1;
        wdata = 8'hA4;
        rinc  = 1'b1;
        tick();
        rst  = 1'b1;
        winc = 1'b0;
        rinc = 1'b0;
        check_reset_outputs("midpkt_reset");
        write_byte(8'hB1, 1'b0);
        write_byte(8'hB2, 1'b1);
        chk("post_reset_pkt_avail", 32'(pkt_avail), 32'd1);
        read_byte("post_reset_b1", 8'hB1, 1'b0);
        read_byte("post_reset_b2", 8'hB2, 1'b1);
        chk("post_reset_rempty", 32'(rempty), 32'd1);

        // Drop counter saturation.
        for (int i = 0; i < 16; i++) begin
            write_byte(8'(i), 1'b0);
        end
        winc = 1'b1;
        for (int i = 0; i < 260; i++) begin
            tick();
        end
        winc = 1'b0;
        chk("drop_saturate", 32'(drop_cnt), 32'd255);
        chk("drop_saturate_wfull", 32'(wfull), 32'd1);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        check_reset_outputs("final_reset");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
